fb_nibble_reader: RTL and testbench

Streams 4-bit pixels out of the composite-video frame buffer's narrow read port (512 × 4-bit view of the shared dual-port BRAM, whose 256 × 8-bit port is written by the pixel producer). On a line-start request it issues sequential nibble reads, absorbs the BRAM read latency, and presents pixels on a valid/ready stream to the composite encoder. It is the read-side counterpart to the byte-wide frame-buffer writer.

---
 rtl/fb_reader_pkg.sv | 13 +
 rtl/fb_nibble_reader_pix_fifo.sv | 67 ++++++
 rtl/fb_nibble_reader.sv | 132 +++++++++++++
 tb/tb_fb_nibble_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_reader_pkg.sv
// Shared types and geometry for the frame-buffer nibble read path.
package fb_reader_pkg;
  localparam int FB_AW    = 9;
  localparam int FB_DW    = 4;
  localparam int FB_DEPTH = 512;
  localparam int LEN_W    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/fb_nibble_reader_pix_fifo.sv
// Small circular pixel buffer; count output feeds the reader's read-credit logic.
module pix_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = din;
        wp_d        = ptr_inc(wp_q);
      end
      if (do_pop) rp_d = ptr_inc(rp_q);
      cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Head is zeroed when empty so a flushed line never leaks a stale pixel.
  assign empty = (cnt_q == '0);
  assign dout  = empty ? '0 : mem_q[rp_q];
  assign cnt   = cnt_q;
endmodule

// File: rtl/fb_nibble_reader.sv
// Line-oriented nibble reader: issues credit-limited BRAM reads and streams
// the returned pixels on a valid/ready interface.
module fb_nibble_reader
  import fb_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [FB_AW-1:0] base_addr,
  input  logic [LEN_W-1:0] line_len,
  input  logic             abort,
  output logic             mem_ceb,
  output logic             mem_oceb,
  output logic [FB_AW-1:0] mem_adb,
  input  logic [FB_DW-1:0] mem_doutb,
  output logic [FB_DW-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done
);
  localparam int D  = RD_LAT + 1;
  localparam int CW = $clog2(D + 1);

  state_e           state_q, state_d;
  logic [FB_AW-1:0] rd_addr_q, rd_addr_d, adb_q, adb_d;
  logic [LEN_W-1:0] rd_left_q, rd_left_d, out_left_q, out_left_d, len_sat;
  logic [RD_LAT:1]  vld_pipe_q, vld_pipe_d;
  logic             done_q, done_d;
  logic             issue, push, pop, flush, fifo_empty;
  logic [CW-1:0]    fifo_cnt;
  logic [3:0]       occ;

  assign len_sat = (line_len > LEN_W'(FB_DEPTH)) ? LEN_W'(FB_DEPTH) : line_len;
  assign flush   = abort && (state_q != IDLE);
  assign pop     = pix_valid && pix_ready;
  assign push    = vld_pipe_q[RD_LAT];

  always_comb begin
    occ = 4'(fifo_cnt);
    for (int i = 1; i <= RD_LAT; i++) occ = occ + 4'(vld_pipe_q[i]);
  end

  // A pixel leaving this cycle frees its slot, which keeps full rate at D = RD_LAT + 1.
  assign issue = (state_q == FETCH) && !abort && ((occ - 4'(pop)) < 4'(D));

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_left_d  = rd_left_q;
    out_left_d = out_left_q;
    adb_d      = adb_q;
    done_d     = 1'b0;
    vld_pipe_d = vld_pipe_q;
    vld_pipe_d[1] = issue;
    for (int i = 2; i <= RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

    if (issue) begin
      adb_d     = rd_addr_q;
      rd_addr_d = rd_addr_q + 1'b1;
      rd_left_d = rd_left_q - 1'b1;
      if (rd_left_q == LEN_W'(1)) state_d = DRAIN;
    end
    if (pop) begin
      out_left_d = out_left_q - 1'b1;
      if (out_left_q == LEN_W'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    if ((state_q == IDLE) && start) begin
      if (len_sat == '0) begin
        done_d = 1'b1;
      end else begin
        rd_addr_d  = base_addr;
        rd_left_d  = len_sat;
        out_left_d = len_sat;
        state_d    = FETCH;
      end
    end
    if (flush) begin
      state_d    = IDLE;
      vld_pipe_d = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      adb_q      <= '0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_left_q  <= rd_left_d;
      out_left_q <= out_left_d;
      adb_q      <= adb_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  pix_fifo #(
    .DEPTH (D),
    .W     (FB_DW),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .din   (mem_doutb),
    .pop   (pop),
    .dout  (pix_data),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  assign pix_valid = !fifo_empty;
  assign mem_ceb   = issue;
  assign mem_adb   = issue ? rd_addr_q : adb_q;
  assign mem_oceb  = 1'b1;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
endmodule

// File: tb/tb_fb_nibble_reader.sv
// Directed bench: one reader per BRAM latency, memory returns the low nibble of each address.
module tb_fb_nibble_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] start = 2'b00;
  logic [8:0] base_addr = '0;
  logic [9:0] line_len = '0;
  logic       abort = 1'b0;
  logic       pix_ready = 1'b1;

  logic       ceb [2];
  logic       oceb [2];
  logic [8:0] adb [2];
  logic [3:0] doutb [2];
  logic [3:0] pdata [2];
  logic       valid [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic [3:0] r1 [2];
  logic [3:0] r2;

  int total = 0, bad = 0, cyc = 0, c0 = 0;
  int iss_n [2], acc_n [2], done_cyc [2];
  logic [1:0] done_seen = 2'b00;
  logic prev_stall [2];
  logic [3:0] prev_data [2];
  logic [3:0] pix0 [$];
  logic [3:0] pix1 [$];
  int pcyc0 [$];
  logic [8:0] adb_log [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: latency-1 port register, plus an always-enabled output register for dut 1.
  always @(posedge clk) begin
    if (ceb[0]) r1[0] <= adb[0][3:0];
    if (ceb[1]) r1[1] <= adb[1][3:0];
    r2 <= r1[1];
  end
  assign doutb[0] = r1[0];
  assign doutb[1] = r2;

  fb_nibble_reader #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .base_addr(base_addr), .line_len(line_len),
    .abort(abort), .mem_ceb(ceb[0]), .mem_oceb(oceb[0]), .mem_adb(adb[0]), .mem_doutb(doutb[0]),
    .pix_data(pdata[0]), .pix_valid(valid[0]), .pix_ready(pix_ready), .busy(busy_w[0]), .done(done_w[0]));

  fb_nibble_reader #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .base_addr(base_addr), .line_len(line_len),
    .abort(abort), .mem_ceb(ceb[1]), .mem_oceb(oceb[1]), .mem_adb(adb[1]), .mem_doutb(doutb[1]),
    .pix_data(pdata[1]), .pix_valid(valid[1]), .pix_ready(pix_ready), .busy(busy_w[1]), .done(done_w[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: logs traffic, checks stall stability and outstanding-read bound.
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || !busy_w[k]) begin
        iss_n[k] = 0;
        acc_n[k] = 0;
      end else begin
        if (prev_stall[k]) begin
          chk("stall_valid", 32'(valid[k]), 32'd1);
          chk("stall_data", 32'(pdata[k]), 32'(prev_data[k]));
        end
        chk("occ_le_D", 32'((iss_n[k] - acc_n[k]) <= (k + 2)), 32'd1);
        if (ceb[k]) begin
          iss_n[k]++;
          if (k == 0) adb_log.push_back(adb[0]);
        end
        if (valid[k] && pix_ready) begin
          acc_n[k]++;
          if (k == 0) begin
            pix0.push_back(pdata[0]);
            pcyc0.push_back(cyc);
          end else pix1.push_back(pdata[1]);
        end
      end
      if (done_w[k] === 1'b1) begin
        done_seen[k] = 1'b1;
        done_cyc[k]  = cyc;
      end
      prev_stall[k] = rst_n && busy_w[k] && valid[k] && !pix_ready && !abort;
      prev_data[k]  = pdata[k];
    end
  end

  task automatic start_line(input logic [8:0] b, input logic [9:0] n, input logic [1:0] which);
    @(negedge clk);
    pix0.delete(); pix1.delete(); pcyc0.delete(); adb_log.delete();
    done_seen = 2'b00;
    base_addr = b; line_len = n; start = which; c0 = cyc;
    @(negedge clk);
    start = 2'b00;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] mask, input int limit, input bit rnd);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rnd) pix_ready = ($urandom_range(0, 2) != 0);
      #3;
      if ((done_seen & mask) == mask) break;
    end
    pix_ready = 1'b1;
    chk(tag, 32'(done_seen & mask), 32'(mask));
  endtask

  task automatic check_line(input string tag, input int k, input int base, input int n);
    int errs, sz;
    logic [3:0] got;
    logic [8:0] a;
    errs = 0;
    sz = (k == 0) ? pix0.size() : pix1.size();
    chk({tag, "_cnt"}, 32'(sz), 32'(n));
    for (int i = 0; i < sz && i < n; i++) begin
      got = (k == 0) ? pix0[i] : pix1[i];
      a   = 9'(base + i);
      if (got !== a[3:0]) errs++;
    end
    chk({tag, "_data"}, 32'(errs), 32'd0);
  endtask

  task automatic check_adb(input string tag, input int base, input int n);
    int errs;
    errs = 0;
    chk({tag, "_cnt"}, 32'(adb_log.size()), 32'(n));
    for (int i = 0; i < adb_log.size(); i++)
      if (adb_log[i] !== 9'(base + i)) errs++;
    chk({tag, "_seq"}, 32'(errs), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ceb"},   32'(ceb[0]),    32'd0);
    chk({tag, "_adb"},   32'(adb[0]),    32'd0);
    chk({tag, "_oceb"},  32'(oceb[0]),   32'd1);
    chk({tag, "_pdata"}, 32'(pdata[0]),  32'd0);
    chk({tag, "_valid"}, 32'(valid[0]),  32'd0);
    chk({tag, "_busy"},  32'(busy_w[0]), 32'd0);
    chk({tag, "_done"},  32'(done_w[0]), 32'd0);
  endtask

  initial begin
    int terr;
    prev_stall = '{1'b0, 1'b0};
    #1 rst_n = 1'b0;
    #2;
    check_reset_outs("rst");
    chk("rst_oceb2", 32'(oceb[1]), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic line: 8 pixels from 0x010 at full rate.
    start_line(9'h010, 10'd8, 2'b01);
    wait_done("B_done", 2'b01, 40, 1'b0);
    check_line("B", 0, 'h010, 8);
    check_adb("B_adb", 'h010, 8);
    terr = 0;
    for (int i = 0; i < pcyc0.size(); i++) if (pcyc0[i] - c0 != 3 + i) terr++;
    chk("B_timing", 32'(terr), 32'd0);
    chk("B_done_cyc", 32'(done_cyc[0] - c0), 32'd11);

    // Address wrap 0x1FE -> 0x001.
    start_line(9'h1FE, 10'd4, 2'b01);
    wait_done("C_done", 2'b01, 40, 1'b0);
    check_line("C", 0, 'h1FE, 4);
    check_adb("C_adb", 'h1FE, 4);

    // Empty line.
    start_line(9'h055, 10'd0, 2'b01);
    wait_done("D_done", 2'b01, 10, 1'b0);
    chk("D_done_cyc", 32'(done_cyc[0] - c0), 32'd1);
    chk("D_no_reads", 32'(adb_log.size()), 32'd0);

    // Oversized line saturates to 512.
    start_line(9'h000, 10'd600, 2'b01);
    wait_done("E_done", 2'b01, 700, 1'b0);
    check_line("E", 0, 0, 512);
    chk("E_reads", 32'(adb_log.size()), 32'd512);

    // Abort with reads in flight, then a fresh line.
    start_line(9'h000, 10'd20, 2'b01);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (pix0.size() >= 3) break;
    end
    chk("F_three_pix", 32'(pix0.size() >= 3), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("F_valid_drop", 32'(valid[0]), 32'd0);
    chk("F_busy_drop", 32'(busy_w[0]), 32'd0);
    repeat (6) @(negedge clk);
    #3;
    chk("F_no_done", 32'(done_seen[0]), 32'd0);
    start_line(9'h108, 10'd4, 2'b01);
    wait_done("F_new_done", 2'b01, 40, 1'b0);
    check_line("F_new", 0, 'h108, 4);

    // Random backpressure on both latencies.
    start_line(9'h0A0, 10'd64, 2'b11);
    wait_done("G_done", 2'b11, 1500, 1'b1);
    check_line("G_lat1", 0, 'h0A0, 64);
    check_line("G_lat2", 1, 'h0A0, 64);

    // Reset mid-line, then a normal line.
    start_line(9'h000, 10'd30, 2'b01);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("H_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_line(9'h020, 10'd4, 2'b01);
    wait_done("H_done", 2'b01, 40, 1'b0);
    check_line("H", 0, 'h020, 4);
    chk("H_first_cyc", 32'((pcyc0.size() > 0) ? pcyc0[0] - c0 : -1), 32'd3);
    chk("H_done_cyc", 32'(done_cyc[0] - c0), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
